// File: rtl/pixel_sensor_ctrl.sv
// Pixel row sequencer: ERASE -> EXPOSE -> CONVERT (256-step ramp) -> READ -> DONE, one gap cycle between phases.
// Every output is a register loaded from the decode of the next state, so nothing combinational reaches the pins.
module pixel_sensor_ctrl #(
  parameter int C_ERASE = 5,
  parameter int C_READ  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] expose_time,
  output logic       erase,
  output logic       expose,
  output logic       convert,
  output logic       read,
  output logic [7:0] counter,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [3:0] {
    S_IDLE, S_ERASE, S_GAP1, S_EXPOSE, S_GAP2, S_CONVERT, S_GAP3, S_READ, S_DONE
  } state_t;

  localparam logic [7:0] ERASE_LAST = 8'(C_ERASE - 1);
  localparam logic [7:0] READ_LAST  = 8'(C_READ - 1);

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic [7:0] exp_lat, exp_lat_nx;
  logic [7:0] exp_last;
  logic       accept;

  // A latched exposure of 0 behaves as 1 cycle.
  assign exp_last = (exp_lat == 8'd0) ? 8'd0 : exp_lat - 8'd1;
  assign accept   = start & ~abort;

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt + 8'd1;
    exp_lat_nx = exp_lat;
    unique case (state)
      S_IDLE, S_DONE: begin
        cnt_nx = 8'd0;
        if (accept) begin
          state_nx   = S_ERASE;
          exp_lat_nx = expose_time;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_ERASE:   if (cnt == ERASE_LAST) state_nx = S_GAP1;
      S_GAP1:    begin state_nx = S_EXPOSE;  cnt_nx = 8'd0; end
      S_EXPOSE:  if (cnt == exp_last)   state_nx = S_GAP2;
      S_GAP2:    begin state_nx = S_CONVERT; cnt_nx = 8'd0; end
      S_CONVERT: if (cnt == 8'd255)     state_nx = S_GAP3;
      S_GAP3:    begin state_nx = S_READ;    cnt_nx = 8'd0; end
      S_READ:    if (cnt == READ_LAST)  state_nx = S_DONE;
      default:   begin state_nx = S_IDLE;    cnt_nx = 8'd0; end
    endcase
    if (abort) begin
      state_nx = S_IDLE;
      cnt_nx   = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= 8'd0;
      exp_lat    <= 8'd0;
      erase      <= 1'b0;
      expose     <= 1'b0;
      convert    <= 1'b0;
      read       <= 1'b0;
      counter    <= 8'd0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      exp_lat    <= exp_lat_nx;
      erase      <= (state_nx == S_ERASE);
      expose     <= (state_nx == S_EXPOSE);
      convert    <= (state_nx == S_CONVERT);
      read       <= (state_nx == S_READ);
      // The ramp value tracks the phase count only while converting.
      counter    <= (state_nx == S_CONVERT) ? cnt_nx : 8'd0;
      busy       <= (state_nx != S_IDLE) && (state_nx != S_DONE);
      frame_done <= (state_nx == S_DONE);
    end
  end

endmodule

// File: tb/tb_pixel_sensor_ctrl.sv
// Directed bench for pixel_sensor_ctrl: frame phase run-lengths, exposure corner cases, back-to-back, abort, async reset.
module tb_pixel_sensor_ctrl;

  localparam int C_ERASE = 5;
  localparam int C_READ  = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] expose_time;
  logic       erase, expose, convert, read, busy, frame_done;
  logic [7:0] counter;

  int n_checks = 0;
  int n_errors = 0;

  pixel_sensor_ctrl #(.C_ERASE(C_ERASE), .C_READ(C_READ)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .expose_time(expose_time),
    .erase(erase), .expose(expose), .convert(convert), .read(read),
    .counter(counter), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // 1 erase, 2 expose, 3 convert, 4 read, 5 gap, 6 done, 0 idle
  function automatic int phase();
    if (erase)           return 1;
    else if (expose)     return 2;
    else if (convert)    return 3;
    else if (read)       return 4;
    else if (frame_done) return 6;
    else if (busy)       return 5;
    return 0;
  endfunction

  always @(negedge clk) begin
    check("onehot", 32'($countones({erase, expose, convert, read}) <= 1), 32'd1);
    if (!convert) check("ctr_zero", 32'(counter), 32'd0);
  end

  // Caller raises start just before the accepting edge; the first sample here is the first ERASE cycle.
  task automatic measure_frame(input string tag, input int t_eff, input bit hold, input bit meddle);
    int ph[$];
    int ln[$];
    int exp_ph[8];
    int exp_ln[8];
    int cur, busy_n, bad_ctr, conv_i;
    bit fin;
    busy_n = 0; bad_ctr = 0; conv_i = 0; fin = 1'b0;
    exp_ph = '{1, 5, 2, 5, 3, 5, 4, 6};
    exp_ln = '{C_ERASE, 1, t_eff, 1, 256, 1, C_READ, 1};
    for (int i = 0; i < 1200 && !fin; i++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      cur = phase();
      if (busy) busy_n++;
      if (cur == 3) begin
        if (counter != conv_i[7:0]) bad_ctr++;
        conv_i++;
      end
      if (meddle) begin
        if (cur == 2) expose_time = 8'd50;
        start = (cur == 3 && counter == 8'd10);
      end
      if (ph.size() > 0 && ph[ph.size()-1] == cur) ln[ln.size()-1] = ln[ln.size()-1] + 1;
      else begin
        ph.push_back(cur);
        ln.push_back(1);
      end
      if (cur == 6) fin = 1'b1;
    end
    check({tag, "_finished"}, 32'(fin), 32'd1);
    check({tag, "_nruns"}, 32'(ph.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < ph.size()) begin
        check($sformatf("%s_phase%0d", tag, i), 32'(ph[i]), 32'(exp_ph[i]));
        check($sformatf("%s_len%0d", tag, i), 32'(ln[i]), 32'(exp_ln[i]));
      end
    end
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(C_ERASE + t_eff + C_READ + 259));
    check({tag, "_ramp"}, 32'(bad_ctr), 32'd0);
  endtask

  task automatic go(input logic [7:0] et);
    @(negedge clk);
    expose_time = et;
    start = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int hits;
    bit found;
    reset = 1'b1; start = 1'b0; abort = 1'b0; expose_time = 8'd0;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ctrl", 32'({erase, expose, convert, read, frame_done}), 32'd0);
    check("rst_counter", 32'(counter), 32'd0);
    idle_cycles(2);
    reset = 1'b0;
    idle_cycles(2);
    check("idle_busy", 32'(busy), 32'd0);

    go(8'd10);   measure_frame("nominal", 10, 1'b0, 1'b0);
    @(negedge clk);
    check("after_done_busy", 32'(busy), 32'd0);
    check("after_done_fd", 32'(frame_done), 32'd0);

    go(8'd0);    measure_frame("exp0", 1, 1'b0, 1'b0);
    go(8'd255);  measure_frame("exp255", 255, 1'b0, 1'b0);

    go(8'd10);   measure_frame("meddle", 10, 1'b0, 1'b1);
    start = 1'b0;
    @(negedge clk);
    check("meddle_no_refire_busy", 32'(busy), 32'd0);
    check("meddle_no_refire_erase", 32'(erase), 32'd0);
    idle_cycles(2);

    go(8'd3);    measure_frame("b2b", 3, 1'b1, 1'b0);
    @(negedge clk);
    check("b2b_erase", 32'(erase), 32'd1);
    check("b2b_busy", 32'(busy), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    check("b2b_abort_busy", 32'(busy), 32'd0);
    check("b2b_abort_erase", 32'(erase), 32'd0);
    @(negedge clk);
    check("idle_start_abort_busy", 32'(busy), 32'd0);
    check("idle_start_abort_erase", 32'(erase), 32'd0);
    abort = 1'b0; start = 1'b0;
    idle_cycles(2);

    go(8'd10);
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (convert && counter == 8'd100) found = 1'b1;
    end
    check("abort_reach_ctr100", 32'(found), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    check("abort_convert", 32'(convert), 32'd0);
    check("abort_counter", 32'(counter), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_fd", 32'(frame_done), 32'd0);
    abort = 1'b0;
    hits = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (frame_done || busy) hits++;
    end
    check("abort_stays_idle", 32'(hits), 32'd0);

    go(8'd10);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (expose) found = 1'b1;
    end
    check("rst_reach_expose", 32'(found), 32'd1);
    idle_cycles(3);
    check("rst_pre_expose", 32'(expose), 32'd1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_expose", 32'(expose), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_fd", 32'(frame_done), 32'd0);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 32'(busy), 32'd0);
    expose_time = 8'd10;
    start = 1'b1;
    measure_frame("post_rst", 10, 1'b0, 1'b0);
    idle_cycles(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
